// File: rtl/fir_frame_pkg.sv
// rtl/fir_frame_pkg.sv - shared types and default sizes for the FIR frame loader
package fir_frame_pkg;

  localparam int DEF_FRAME_LEN   = 256;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef logic [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_frame_watchdog.sv
// rtl/fir_frame_watchdog.sv - WAIT-state cycle counter with sticky timeout flag
//  clk, rst_n   clock, asynchronous active-low reset
//  in_wait      loader is in WAIT this cycle
//  filt_rdy     filter acknowledge (a normal exit wins over expiry)
//  expire       this is the last allowed WAIT cycle and filt_rdy is still low
//  timeout_err  sticky until reset
module fir_frame_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  input  logic filt_rdy,
  output logic expire,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds the number of WAIT cycles already completed; expiry leaves
  // WAIT so the count never needs to go past TIMEOUT_CYC-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!in_wait) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire = in_wait && !filt_rdy && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fir_frame_loader.sv
// rtl/fir_frame_loader.sv - packs a sample stream into a frame and hands it to the FIR filter
//  Optional WAIT watchdog: define FIR_FRAME_TIMEOUT_EN.
//  clk, rst_n           clock, asynchronous active-low reset
//  s_data/s_valid/s_ready  input sample stream, transfer = s_valid & s_ready
//  start_flg            one-cycle pulse when frame_out is complete
//  filt_rdy             filter done (level), releases the held frame
//  frame_out            FRAME_LEN x DATA_W, entry k at [k*DATA_W +: DATA_W], 0 = oldest
//  busy                 high in LAUNCH or WAIT
//  frame_cnt            acknowledged frames, wraps
//  timeout_err          sticky watchdog error, 0 without the watchdog
module fir_frame_loader #(
  parameter int FRAME_LEN   = fir_frame_pkg::DEF_FRAME_LEN,
  parameter int DATA_W      = fir_frame_pkg::DEF_DATA_W,
  parameter int CNT_W       = fir_frame_pkg::DEF_CNT_W,
  parameter int TIMEOUT_CYC = fir_frame_pkg::DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        start_flg,
  input  logic                        filt_rdy,
  output logic [FRAME_LEN*DATA_W-1:0] frame_out,
  output logic                        busy,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic                        timeout_err
);

  import fir_frame_pkg::*;

  localparam int PTR_W = $clog2(FRAME_LEN);

  if (FRAME_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("fir_frame_loader: FRAME_LEN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [DATA_W-1:0] frame_q [FRAME_LEN];
  logic              xfer;
  logic              last_xfer;
  logic              wd_expire;

  assign xfer      = s_valid && s_ready;
  assign last_xfer = xfer && (wr_ptr_q == PTR_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_xfer) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (filt_rdy || wd_expire) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // s_ready depends on state only, never on s_valid.
  always_comb begin
    s_ready   = 1'b0;
    start_flg = 1'b0;
    busy      = 1'b0;
    case (state_q)
      FILL:    s_ready = 1'b1;
      LAUNCH:  begin start_flg = 1'b1; busy = 1'b1; end
      WAIT:    busy = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else if (xfer) begin
      wr_ptr_q <= last_xfer ? '0 : wr_ptr_q + PTR_W'(1);
    end
  end

  // Only FILL transfers write, so the frame is frozen through LAUNCH and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) frame_q[i] <= '0;
    end else if (xfer) begin
      frame_q[wr_ptr_q] <= s_data;
    end
  end

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_flat
    assign frame_out[g*DATA_W +: DATA_W] = frame_q[g];
  end

  // Counted only on a filter acknowledge; a watchdog exit is not a handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (state_q == WAIT && filt_rdy) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef FIR_FRAME_TIMEOUT_EN
  fir_frame_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_wait     (state_q == WAIT),
    .filt_rdy    (filt_rdy),
    .expire      (wd_expire),
    .timeout_err (timeout_err)
  );
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_frame_loader.sv
// tb/tb_fir_frame_loader.sv - directed self-checking bench for fir_frame_loader
module tb_fir_frame_loader;

  import fir_frame_pkg::*;

  localparam int FL = 256;
  localparam int DW = 8;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DW-1:0]     s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              start_flg;
  logic              filt_rdy = 1'b0;
  logic [FL*DW-1:0]  frame_out;
  logic              busy;
  logic [CW-1:0]     frame_cnt;
  logic              timeout_err;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int hi_cnt;

  fir_frame_loader #(
    .FRAME_LEN   (FL),
    .DATA_W      (DW),
    .CNT_W       (CW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .start_flg   (start_flg),
    .filt_rdy    (filt_rdy),
    .frame_out   (frame_out),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start_flg) pulses++;

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: zeros, 1: k, 2: ~k, 3: k+7
  function automatic sample_t exp_byte(input int mode, input int k);
    sample_t v;
    case (mode)
      1:       v = sample_t'(k);
      2:       v = ~sample_t'(k);
      3:       v = sample_t'(k + 7);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int frame_mism(input int mode);
    int m = 0;
    for (int k = 0; k < FL; k++)
      if (frame_out[k*DW +: DW] !== exp_byte(mode, k)) m++;
    return m;
  endfunction

  // Holds one sample until accepted; returns #1 after the accepting edge.
  task automatic push(input sample_t d, input int gap);
    int n = 0;
    repeat (gap) begin s_valid = 1'b0; tick(); end
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin tick(); n++; end
    if (n == 200) chk("push_wait", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic push_frame(input int mode, input int gap, input int count);
    for (int k = 0; k < count; k++) push(exp_byte(mode, k), gap);
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(start_flg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_frame", 32'(frame_mism(0)), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(s_ready), 32'd1);

    // 2: continuous stream 0..255, filter already ready
    filt_rdy = 1'b1;
    pulses = 0;
    push_frame(1, 0, FL);
    chk("t2_launch_start", 32'(start_flg), 32'd1);
    chk("t2_launch_ready", 32'(s_ready), 32'd0);
    chk("t2_launch_busy", 32'(busy), 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick();
    chk("t2_wait_start", 32'(start_flg), 32'd0);
    chk("t2_wait_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    chk("t2_fill_ready", 32'(s_ready), 32'd1);
    chk("t2_fill_busy", 32'(busy), 32'd0);
    chk("t2_cnt", 32'(frame_cnt), 32'd1);
    chk("t2_frame", 32'(frame_mism(1)), 32'd0);
    chk("t2_pulses", 32'(pulses), 32'd1);

    // 3: same data, one valid every third cycle
    pulses = 0;
    push_frame(1, 2, FL);
    repeat (4) tick();
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_frame", 32'(frame_mism(1)), 32'd0);
    chk("t3_cnt", 32'(frame_cnt), 32'd2);

    // 4: filter stalls 50 cycles while upstream pushes 8'hAA
    filt_rdy = 1'b0;
    push_frame(2, 0, FL);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    hi_cnt = 0;
    repeat (50) begin
      if (s_ready) hi_cnt++;
      tick();
    end
    chk("t4_stall_ready", 32'(hi_cnt), 32'd0);
    chk("t4_stall_busy", 32'(busy), 32'd1);
    chk("t4_stall_frame", 32'(frame_mism(2)), 32'd0);
    chk("t4_stall_cnt", 32'(frame_cnt), 32'd2);
`ifndef FIR_FRAME_TIMEOUT_EN
    chk("t4_no_wdog", 32'(timeout_err), 32'd0);
`endif
    filt_rdy = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t4_release_ready", 32'(s_ready), 32'd1);
    chk("t4_release_cnt", 32'(frame_cnt), 32'd3);
    chk("t4_release_frame", 32'(frame_mism(2)), 32'd0);

    // 5: reset after 100 samples, then a clean frame
    push_frame(3, 0, 100);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_frame", 32'(frame_mism(0)), 32'd0);
    chk("t5_rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    push_frame(3, 0, FL);
    chk("t5_launch", 32'(start_flg), 32'd1);
    chk("t5_frame", 32'(frame_mism(3)), 32'd0);
    repeat (2) tick();
    chk("t5_cnt", 32'(frame_cnt), 32'd1);

`ifdef FIR_FRAME_TIMEOUT_EN
    // 6: watchdog with TIMEOUT_CYC=16
    filt_rdy = 1'b0;
    push_frame(1, 0, FL);
    repeat (16) tick();
    chk("t6_last_wait_busy", 32'(busy), 32'd1);
    chk("t6_last_wait_terr", 32'(timeout_err), 32'd0);
    tick();
    chk("t6_to_ready", 32'(s_ready), 32'd1);
    chk("t6_to_terr", 32'(timeout_err), 32'd1);
    chk("t6_to_cnt", 32'(frame_cnt), 32'd1);
    // filt_rdy arriving in the 16th WAIT cycle is a normal exit
    push_frame(1, 0, FL);
    repeat (16) tick();
    filt_rdy = 1'b1;
    tick();
    chk("t6_edge_ready", 32'(s_ready), 32'd1);
    chk("t6_edge_cnt", 32'(frame_cnt), 32'd2);
    chk("t6_sticky", 32'(timeout_err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
